// File: rtl/logic32_pkg.sv
// Shared constants for the 32-bit registered logic unit: width, opcode encodings and reset value.
package logic32_pkg;

  localparam int unsigned WIDTH = 32;

  localparam logic [1:0] OPRN_AND = 2'b00;
  localparam logic [1:0] OPRN_OR  = 2'b01;
  localparam logic [1:0] OPRN_NOR = 2'b10;
  localparam logic [1:0] OPRN_INV = 2'b11;

  localparam logic [WIDTH-1:0] RESULT_RST = 32'h0;

  function automatic logic is_zero(input logic [WIDTH-1:0] val);
    return (val == '0);
  endfunction

endpackage

// File: rtl/logic32_core.sv
// Combinational logic slice: per-bit AND/OR/NOR/INV gate arrays feeding a 4:1 opcode mux.
module logic32_core
  import logic32_pkg::*;
#(
  parameter int unsigned WIDTH = logic32_pkg::WIDTH
) (
  input  logic [1:0]       oprn_i,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  output logic [WIDTH-1:0] y_o
);

  logic [WIDTH-1:0] and_y;
  logic [WIDTH-1:0] or_y;
  logic [WIDTH-1:0] nor_y;
  logic [WIDTH-1:0] inv_y;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign and_y[i] = op1_i[i] & op2_i[i];
    assign or_y[i]  = op1_i[i] | op2_i[i];
    assign nor_y[i] = ~(op1_i[i] | op2_i[i]);
    assign inv_y[i] = ~op1_i[i];
  end

  // Unknown opcodes fall back to AND so the mux never holds state.
  always_comb begin
    y_o = and_y;
    case (oprn_i)
      OPRN_AND: y_o = and_y;
      OPRN_OR:  y_o = or_y;
      OPRN_NOR: y_o = nor_y;
      OPRN_INV: y_o = inv_y;
      default:  y_o = and_y;
    endcase
  end

endmodule

// File: rtl/logic32_unit.sv
// Registered 32-bit logic unit: result and valid one cycle after each accepted request.
// Optional registered ZERO flag enabled by defining LOGIC32_ZERO_FLAG_EN.
module logic32_unit
  import logic32_pkg::*;
#(
  parameter int unsigned WIDTH = logic32_pkg::WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  input  logic [1:0]       OPRN,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  output logic [WIDTH-1:0] RESULT,
  output logic             OUT_VALID
`ifdef LOGIC32_ZERO_FLAG_EN
  ,
  output logic             ZERO
`endif
);

  logic [WIDTH-1:0] core_y;
  logic [WIDTH-1:0] result_d, result_q;
  logic             valid_d, valid_q;

  logic32_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .oprn_i (OPRN),
    .op1_i  (OP1),
    .op2_i  (OP2),
    .y_o    (core_y)
  );

  always_comb begin
    result_d = result_q;
    valid_d  = 1'b0;
    if (IN_VALID) begin
      result_d = core_y;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      result_q <= RESULT_RST;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign RESULT    = result_q;
  assign OUT_VALID = valid_q;

`ifdef LOGIC32_ZERO_FLAG_EN
  logic zero_d, zero_q;

  always_comb begin
    zero_d = zero_q;
    if (IN_VALID) begin
      zero_d = is_zero(core_y);
    end
  end

  // Reset value of 1 matches the cleared RESULT.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      zero_q <= 1'b1;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign ZERO = zero_q;
`endif

endmodule

// File: tb/tb_logic32_unit.sv
// Directed self-checking bench for logic32_unit with hand-computed expected values.
module tb_logic32_unit;

  logic        CLK;
  logic        RST;
  logic        IN_VALID;
  logic [1:0]  OPRN;
  logic [31:0] OP1;
  logic [31:0] OP2;
  logic [31:0] RESULT;
  logic        OUT_VALID;
`ifdef LOGIC32_ZERO_FLAG_EN
  logic        ZERO;
`endif

  int n_total = 0;
  int n_pass  = 0;

  logic32_unit dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .OPRN      (OPRN),
    .OP1       (OP1),
    .OP2       (OP2),
    .RESULT    (RESULT),
    .OUT_VALID (OUT_VALID)
`ifdef LOGIC32_ZERO_FLAG_EN
    ,
    .ZERO      (ZERO)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    IN_VALID = v;
    OPRN     = op;
    OP1      = a;
    OP2      = b;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_zero(input string tag, input logic exp);
`ifdef LOGIC32_ZERO_FLAG_EN
    check(tag, {31'h0, ZERO}, {31'h0, exp});
`endif
  endtask

  initial begin
    RST = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    #2;
    check("reset_result", RESULT, 32'h0);
    check("reset_valid", {31'h0, OUT_VALID}, 32'h0);
    check_zero("reset_zero", 1'b1);

    tick();
    RST = 1'b1;
    tick();

    // NOR 27,13 -> ~31
    drive(1'b1, 2'b10, 32'd27, 32'd13);
    tick();
    check("nor_result", RESULT, 32'hFFFFFFE0);
    check("nor_valid", {31'h0, OUT_VALID}, 32'h1);
    check_zero("nor_zero", 1'b0);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    check("idle_valid", {31'h0, OUT_VALID}, 32'h0);
    check("idle_hold", RESULT, 32'hFFFFFFE0);

    // AND
    drive(1'b1, 2'b00, 32'd26, 32'd19);
    tick();
    check("and_small", RESULT, 32'h00000012);
    drive(1'b1, 2'b00, 32'hFFFFFFFF, 32'hA5A5A5A5);
    tick();
    check("and_mask", RESULT, 32'hA5A5A5A5);
    check("and_valid", {31'h0, OUT_VALID}, 32'h1);

    // INV
    drive(1'b1, 2'b11, 32'hFFFFFFFF, 32'h00001234);
    tick();
    check("inv_ones", RESULT, 32'h00000000);
    check_zero("inv_zero", 1'b1);
    drive(1'b0, 2'b01, 32'h12345678, 32'h1);
    tick();
    check("idle_hold_zero", RESULT, 32'h00000000);
    check_zero("idle_zero_hold", 1'b1);
    drive(1'b1, 2'b11, 32'h0F0F0000, 32'hFFFFFFFF);
    tick();
    check("inv_pattern", RESULT, 32'hF0F0FFFF);
    check_zero("inv_nonzero", 1'b0);

    // OR back-to-back
    drive(1'b1, 2'b01, 32'hFFFFFFFF, 32'h0000FFFF);
    tick();
    check("or_b2b_first", RESULT, 32'hFFFFFFFF);
    check("or_b2b_valid1", {31'h0, OUT_VALID}, 32'h1);
    drive(1'b1, 2'b01, 32'h0, 32'h0);
    tick();
    check("or_b2b_second", RESULT, 32'h00000000);
    check("or_b2b_valid2", {31'h0, OUT_VALID}, 32'h1);
    drive(1'b1, 2'b01, 32'hF0000000, 32'h0000000F);
    tick();
    check("or_mixed", RESULT, 32'hF000000F);

    // NOR producing all zeros
    drive(1'b1, 2'b10, 32'hFFFF0000, 32'h0000FFFF);
    tick();
    check("nor_zero_result", RESULT, 32'h00000000);

    // Async reset mid-run while OUT_VALID is high
    drive(1'b1, 2'b01, 32'h00C0FFEE, 32'h0);
    tick();
    check("pre_reset_result", RESULT, 32'h00C0FFEE);
    check("pre_reset_valid", {31'h0, OUT_VALID}, 32'h1);
    RST = 1'b0;
    #1;
    check("async_reset_result", RESULT, 32'h0);
    check("async_reset_valid", {31'h0, OUT_VALID}, 32'h0);
    check_zero("async_reset_zero", 1'b1);

    // Request during reset is lost
    drive(1'b1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    check("collision_result", RESULT, 32'h0);
    check("collision_valid", {31'h0, OUT_VALID}, 32'h0);

    // First edge after release accepts the pending request
    RST = 1'b1;
    tick();
    check("post_reset_result", RESULT, 32'hFFFFFFFF);
    check("post_reset_valid", {31'h0, OUT_VALID}, 32'h1);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    check("final_valid", {31'h0, OUT_VALID}, 32'h0);
    check("final_hold", RESULT, 32'hFFFFFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
